// File: rtl/rv32i_lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit: FSM states, access
// size encodings, byte-enable masks and the alignment check.
package rv32i_lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2,
      ST_MIS  = 2'd3
   } lsu_state_e;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_DBL  = 2'd3;

   localparam logic [7:0] BE_BYTE = 8'h01;
   localparam logic [7:0] BE_HALF = 8'h03;
   localparam logic [7:0] BE_WORD = 8'h0F;
   localparam logic [7:0] BE_DBL  = 8'hFF;

   function automatic logic [7:0] size_mask(input logic [1:0] size);
      case (size)
         SZ_BYTE: return BE_BYTE;
         SZ_HALF: return BE_HALF;
         SZ_WORD: return BE_WORD;
         default: return BE_DBL;
      endcase
   endfunction

   // A double access is only legal on a 64-bit data path.
   function automatic logic lsu_misaligned(input logic [1:0] size, input logic [2:0] ofs,
                                           input logic dbl_ok);
      logic [2:0] low_mask;
      case (size)
         SZ_BYTE: low_mask = 3'b000;
         SZ_HALF: low_mask = 3'b001;
         SZ_WORD: low_mask = 3'b011;
         default: low_mask = 3'b111;
      endcase
      return (|(ofs & low_mask)) || (size == SZ_DBL && !dbl_ok);
   endfunction

endpackage

// File: rtl/rv32i_lsu_align.sv
// Lane steering for the LSU: byte enables, store data replication and
// load data shift plus sign/zero extension.
module rv32i_lsu_align
   import rv32i_lsu_pkg::*;
#(
   parameter int WORD_WTH = 32
) (
   input  logic [1:0]                       size,
   input  logic                             zext,
   input  logic [$clog2(WORD_WTH/8)-1:0]    ofs,
   input  logic [WORD_WTH-1:0]              wraw,
   input  logic [WORD_WTH-1:0]              rraw,
   output logic [WORD_WTH/8-1:0]            be,
   output logic [WORD_WTH-1:0]              wdata,
   output logic [WORD_WTH-1:0]              rdata
);

   localparam int NB = WORD_WTH / 8;

   logic [15:0]         be_ext;
   logic [WORD_WTH-1:0] sh;
   logic [WORD_WTH-1:0] sl;
   logic [6:0]          pad;

   always_comb begin
      be_ext = 16'(size_mask(size)) << ofs;
      be     = be_ext[NB-1:0];
   end

   always_comb begin
      wdata = '0;
      for (int i = 0; i < NB; i++) begin
         case (size)
            SZ_BYTE: wdata[8*i +: 8] = wraw[7:0];
            SZ_HALF: wdata[8*i +: 8] = wraw[8*(i%2) +: 8];
            SZ_WORD: wdata[8*i +: 8] = wraw[8*(i%4) +: 8];
            default: wdata[8*i +: 8] = wraw[8*i +: 8];
         endcase
      end
   end

   // Move the addressed lane to the top, then shift back down arithmetically or logically.
   always_comb begin
      sh = rraw >> {ofs, 3'b000};
      case (size)
         SZ_BYTE: pad = 7'(WORD_WTH - 8);
         SZ_HALF: pad = 7'(WORD_WTH - 16);
         SZ_WORD: pad = 7'(WORD_WTH - 32);
         default: pad = 7'd0;
      endcase
      sl    = sh << pad;
      rdata = zext ? (sl >> pad) : WORD_WTH'($signed(sl) >>> pad);
   end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: accepts one pipeline access at a time and runs it
// over the single-outstanding DTCM request/grant/rvalid bus with a timeout.
//
//   state | meaning
//   IDLE  | ready for a new access
//   REQ   | dtcm_req_o raised, waiting for grant
//   RSP   | granted, waiting for rvalid
//   MIS   | misaligned/illegal access, one-cycle error response
module rv32i_lsu
   import rv32i_lsu_pkg::*;
#(
   parameter int WORD_WTH    = 32,
   parameter int ADDR_WTH    = 32,
   parameter int REG_INX_WTH = 5,
   parameter int TMO_WTH     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     lsu_valid_i,
   output logic                     lsu_ready_o,
   input  logic                     lsu_we_i,
   input  logic [1:0]               lsu_size_i,
   input  logic                     lsu_unsigned_i,
   input  logic [ADDR_WTH-1:0]      lsu_addr_i,
   input  logic [WORD_WTH-1:0]      lsu_wdata_i,
   input  logic [REG_INX_WTH-1:0]   lsu_rd_inx_i,
   input  logic                     lsu_flush_i,
   output logic                     lsu_rsp_valid_o,
   output logic [WORD_WTH-1:0]      lsu_rdata_o,
   output logic [REG_INX_WTH-1:0]   lsu_rd_inx_o,
   output logic                     lsu_misalign_o,
   output logic                     lsu_err_o,
   output logic                     lsu_busy_o,
   output logic                     dtcm_req_o,
   input  logic                     dtcm_gnt_i,
   output logic                     dtcm_we_o,
   output logic [WORD_WTH/8-1:0]    dtcm_be_o,
   output logic [ADDR_WTH-1:0]      dtcm_addr_o,
   output logic [WORD_WTH-1:0]      dtcm_wdata_o,
   input  logic                     dtcm_rvalid_i,
   input  logic [WORD_WTH-1:0]      dtcm_rdata_i
);

   localparam int NB      = WORD_WTH / 8;
   localparam int OFS_WTH = $clog2(NB);

   lsu_state_e               state, state_nxt;
   logic [TMO_WTH-1:0]       cnt;
   logic                     accept, tmo, gnt_take, mis_in;
   logic                     we_q, zext_q, kill_q, rsp_q, err_q;
   logic [1:0]               size_q;
   logic [REG_INX_WTH-1:0]   rd_q;
   logic [ADDR_WTH-1:0]      addr_q;
   logic [WORD_WTH-1:0]      wdata_q, rdata_q;
   logic [NB-1:0]            be_a;
   logic [WORD_WTH-1:0]      wdata_a, ld_data;

   assign mis_in   = lsu_misaligned(lsu_size_i, 3'(lsu_addr_i[OFS_WTH-1:0]), WORD_WTH == 64);
   assign accept   = lsu_valid_i && state == ST_IDLE && !lsu_flush_i;
   assign tmo      = (state == ST_REQ || state == ST_RSP) && cnt == '1;
   assign gnt_take = state == ST_REQ && !tmo && dtcm_gnt_i;

   rv32i_lsu_align #(.WORD_WTH(WORD_WTH)) u_align (
      .size  (size_q),
      .zext  (zext_q),
      .ofs   (addr_q[OFS_WTH-1:0]),
      .wraw  (wdata_q),
      .rraw  (dtcm_rdata_i),
      .be    (be_a),
      .wdata (wdata_a),
      .rdata (ld_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (accept)
            cnt <= '0;
         else if (state == ST_REQ || state == ST_RSP)
            cnt <= cnt + TMO_WTH'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (accept) state_nxt = mis_in ? ST_MIS : ST_REQ;
         ST_REQ: begin
            if (tmo)              state_nxt = ST_IDLE;
            else if (dtcm_gnt_i)  state_nxt = ST_RSP;
            else if (lsu_flush_i) state_nxt = ST_IDLE;
         end
         ST_RSP:  if (dtcm_rvalid_i || tmo) state_nxt = ST_IDLE;
         ST_MIS:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q    <= 1'b0;
         zext_q  <= 1'b0;
         size_q  <= SZ_BYTE;
         rd_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         we_q    <= lsu_we_i;
         zext_q  <= lsu_unsigned_i;
         size_q  <= lsu_size_i;
         rd_q    <= lsu_rd_inx_i;
         addr_q  <= lsu_addr_i;
         wdata_q <= lsu_wdata_i;
      end
   end

   // A flushed access still drains the bus but its completion is swallowed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         kill_q  <= 1'b0;
         rsp_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         rsp_q <= 1'b0;
         err_q <= 1'b0;
         if (accept)
            kill_q <= 1'b0;
         else if (lsu_flush_i && (state == ST_RSP || gnt_take))
            kill_q <= 1'b1;
         if (state == ST_RSP && dtcm_rvalid_i) begin
            rsp_q   <= !(kill_q || lsu_flush_i);
            rdata_q <= we_q ? '0 : ld_data;
         end else if (tmo && !(kill_q || lsu_flush_i)) begin
            rsp_q   <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
         end
      end
   end

   always_comb begin
      lsu_ready_o     = state == ST_IDLE;
      lsu_busy_o      = state != ST_IDLE;
      dtcm_req_o      = state == ST_REQ && !tmo;
      lsu_misalign_o  = state == ST_MIS;
      lsu_rsp_valid_o = state == ST_MIS || rsp_q;
      lsu_err_o       = err_q;
      lsu_rdata_o     = rsp_q ? rdata_q : '0;
      lsu_rd_inx_o    = lsu_rsp_valid_o ? rd_q : '0;
      dtcm_we_o       = dtcm_req_o && we_q;
      dtcm_be_o       = dtcm_req_o ? be_a : '0;
      dtcm_addr_o     = dtcm_req_o ? {addr_q[ADDR_WTH-1:OFS_WTH], {OFS_WTH{1'b0}}} : '0;
      dtcm_wdata_o    = dtcm_req_o ? wdata_a : '0;
   end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Self-checking bench for rv32i_lsu: table of single accesses plus hand-written
// flush, timeout and reset sequences, with a scoreboard on the response port.
module tb_rv32i_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lsu_valid_i = 1'b0, lsu_we_i = 1'b0, lsu_unsigned_i = 1'b0, lsu_flush_i = 1'b0;
   logic [1:0]  lsu_size_i = '0;
   logic [31:0] lsu_addr_i = '0, lsu_wdata_i = '0;
   logic [4:0]  lsu_rd_inx_i = '0;
   logic        dtcm_gnt_i = 1'b0, dtcm_rvalid_i = 1'b0;
   logic [31:0] dtcm_rdata_i = '0;
   logic        lsu_ready_o, lsu_rsp_valid_o, lsu_misalign_o, lsu_err_o, lsu_busy_o;
   logic [31:0] lsu_rdata_o;
   logic [4:0]  lsu_rd_inx_o;
   logic        dtcm_req_o, dtcm_we_o;
   logic [3:0]  dtcm_be_o;
   logic [31:0] dtcm_addr_o, dtcm_wdata_o;

   rv32i_lsu #(.WORD_WTH(32), .ADDR_WTH(32), .REG_INX_WTH(5), .TMO_WTH(3)) dut (
      .clk(clk), .rst(rst),
      .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_we_i(lsu_we_i),
      .lsu_size_i(lsu_size_i), .lsu_unsigned_i(lsu_unsigned_i), .lsu_addr_i(lsu_addr_i),
      .lsu_wdata_i(lsu_wdata_i), .lsu_rd_inx_i(lsu_rd_inx_i), .lsu_flush_i(lsu_flush_i),
      .lsu_rsp_valid_o(lsu_rsp_valid_o), .lsu_rdata_o(lsu_rdata_o), .lsu_rd_inx_o(lsu_rd_inx_o),
      .lsu_misalign_o(lsu_misalign_o), .lsu_err_o(lsu_err_o), .lsu_busy_o(lsu_busy_o),
      .dtcm_req_o(dtcm_req_o), .dtcm_gnt_i(dtcm_gnt_i), .dtcm_we_o(dtcm_we_o),
      .dtcm_be_o(dtcm_be_o), .dtcm_addr_o(dtcm_addr_o), .dtcm_wdata_o(dtcm_wdata_o),
      .dtcm_rvalid_i(dtcm_rvalid_i), .dtcm_rdata_i(dtcm_rdata_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        zext;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] bus_rdata;
      int          gnt_dly;
      logic        mis;
      logic [3:0]  be;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic [31:0] rdata;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic [4:0]  rd;
      logic        mis;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] rdata, input logic [4:0] rd, input logic mis,
                           input logic err, input int at);
      exp_t e;
      e.rdata = rdata; e.rd = rd; e.mis = mis; e.err = err; e.cyc = at;
      sb.push_back(e);
   endtask

   // Every response must match the oldest pending expectation, including its cycle.
   always @(negedge clk) begin
      if (lsu_rsp_valid_o === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp actual=1 required=0 at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_rdata", 128'(lsu_rdata_o), 128'(e.rdata));
            check("rsp_rd_inx", 128'(lsu_rd_inx_o), 128'(e.rd));
            check("rsp_misalign", 128'(lsu_misalign_o), 128'(e.mis));
            check("rsp_err", 128'(lsu_err_o), 128'(e.err));
            check("rsp_cycle", 128'(cyc), 128'(e.cyc));
         end
      end
   end

   task automatic check_quiet(input string name);
      check(name, 128'({dtcm_req_o, dtcm_we_o, dtcm_be_o, dtcm_addr_o, dtcm_wdata_o,
                        lsu_rsp_valid_o, lsu_rdata_o, lsu_rd_inx_o, lsu_misalign_o,
                        lsu_err_o, lsu_busy_o, lsu_ready_o}), 128'(1));
   endtask

   task automatic issue(input logic we, input logic [1:0] size, input logic zext,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
      lsu_valid_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_unsigned_i = zext;
      lsu_addr_i = addr; lsu_wdata_i = wdata; lsu_rd_inx_i = rd;
   endtask

   // After the accept edge, scramble the inputs so only registered copies can be used.
   task automatic scramble();
      lsu_valid_i = 1'b0;
      lsu_we_i = 1'($urandom); lsu_size_i = 2'($urandom); lsu_unsigned_i = 1'($urandom);
      lsu_addr_i = $urandom; lsu_wdata_i = $urandom; lsu_rd_inx_i = 5'($urandom);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int acc, nreq;
      step();
      issue(v.we, v.size, v.zext, v.addr, v.wdata, v.rd);
      acc = cyc;
      if (v.mis) push_exp(32'h0, v.rd, 1'b1, 1'b0, acc + 1);
      else       push_exp(v.rdata, v.rd, 1'b0, 1'b0, acc + 3 + v.gnt_dly);
      @(negedge clk);
      check($sformatf("v%0d_ready", idx), 128'(lsu_ready_o), 128'(1));
      step();
      scramble();
      dtcm_rdata_i = $urandom;
      if (v.mis) begin
         @(negedge clk);
         check($sformatf("v%0d_mis_noreq", idx), 128'(dtcm_req_o), 128'(0));
         step();
         @(negedge clk);
         check($sformatf("v%0d_mis_ready", idx), 128'(lsu_ready_o), 128'(1));
      end else begin
         nreq = 0;
         for (int k = 0; k <= v.gnt_dly; k++) begin
            if (k > 0) step();
            dtcm_gnt_i = (k == v.gnt_dly);
            @(negedge clk);
            if (dtcm_req_o) nreq++;
            if (k == 0) begin
               check($sformatf("v%0d_be", idx), 128'(dtcm_be_o), 128'(v.be));
               check($sformatf("v%0d_addr", idx), 128'(dtcm_addr_o), 128'(v.daddr));
               check($sformatf("v%0d_wdata", idx), 128'(dtcm_wdata_o), 128'(v.dwdata));
               check($sformatf("v%0d_we", idx), 128'(dtcm_we_o), 128'(v.we));
            end
         end
         check($sformatf("v%0d_req_cycles", idx), 128'(nreq), 128'(v.gnt_dly + 1));
         step();
         dtcm_gnt_i = 1'b0;
         dtcm_rvalid_i = 1'b1;
         dtcm_rdata_i = v.bus_rdata;
         @(negedge clk);
         check($sformatf("v%0d_req_released", idx), 128'(dtcm_req_o), 128'(0));
         step();
         dtcm_rvalid_i = 1'b0;
         dtcm_rdata_i = $urandom;
         @(negedge clk);
         check($sformatf("v%0d_idle", idx), 128'({lsu_ready_o, lsu_busy_o}), 128'(2'b10));
      end
   endtask

   vec_t vecs[13];

   initial begin
      int nreq;
      vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,         5'd1,  32'h80FF_FF12, 0, 1'b0, 4'b1000, 32'h100, 32'h0,         32'hFFFF_FF80};
      vecs[1]  = '{1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_ABCD, 5'd2,  32'h5555_5555, 3, 1'b0, 4'b1100, 32'h200, 32'hABCD_ABCD, 32'h0};
      vecs[2]  = '{1'b0, 2'd2, 1'b0, 32'h301, 32'h0,         5'd3,  32'h0,         0, 1'b1, 4'b0000, 32'h0,   32'h0,         32'h0};
      vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h101, 32'h0,         5'd4,  32'h1234_8056, 1, 1'b0, 4'b0010, 32'h100, 32'h0,         32'h0000_0080};
      vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h402, 32'h0,         5'd5,  32'h9ABC_0000, 0, 1'b0, 4'b1100, 32'h400, 32'h0,         32'hFFFF_9ABC};
      vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h400, 32'h0,         5'd6,  32'h0000_F00D, 2, 1'b0, 4'b0011, 32'h400, 32'h0,         32'h0000_F00D};
      vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h508, 32'h0,         5'd7,  32'hDEAD_BEEF, 0, 1'b0, 4'b1111, 32'h508, 32'h0,         32'hDEAD_BEEF};
      vecs[7]  = '{1'b1, 2'd0, 1'b0, 32'h601, 32'h1234_56A5, 5'd8,  32'hFFFF_FFFF, 1, 1'b0, 4'b0010, 32'h600, 32'hA5A5_A5A5, 32'h0};
      vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h70C, 32'h1122_3344, 5'd9,  32'h0,         0, 1'b0, 4'b1111, 32'h70C, 32'h1122_3344, 32'h0};
      vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h203, 32'h0,         5'd10, 32'h0,         0, 1'b1, 4'b0000, 32'h0,   32'h0,         32'h0};
      vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h800, 32'h0,         5'd11, 32'h0,         0, 1'b1, 4'b0000, 32'h0,   32'h0,         32'h0};
      vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h000, 32'h0,         5'd12, 32'hFFFF_7FFF, 0, 1'b0, 4'b0011, 32'h000, 32'h0,         32'h0000_7FFF};
      vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h006, 32'h0,         5'd13, 32'h0055_0000, 1, 1'b0, 4'b0100, 32'h004, 32'h0,         32'h0000_0055};

      #2 rst = 1'b0;
      @(negedge clk);
      check_quiet("reset_outputs");
      step();
      rst = 1'b1;

      for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

      // Bus never grants: req for 7 cycles, then an error response; a late rvalid is ignored.
      step();
      issue(1'b0, 2'd2, 1'b0, 32'h900, 32'h0, 5'd17);
      push_exp(32'h0, 5'd17, 1'b0, 1'b1, cyc + 9);
      step();
      scramble();
      nreq = 0;
      for (int k = 0; k < 12; k++) begin
         dtcm_rvalid_i = (k == 10);
         @(negedge clk);
         if (dtcm_req_o) nreq++;
         if (k == 8) check("tmo_idle", 128'({lsu_ready_o, lsu_busy_o}), 128'(2'b10));
         step();
      end
      dtcm_rvalid_i = 1'b0;
      check("tmo_req_cycles", 128'(nreq), 128'(7));

      // Flush while waiting for grant.
      issue(1'b0, 2'd2, 1'b0, 32'hA00, 32'h0, 5'd18);
      step();
      scramble();
      lsu_flush_i = 1'b1;
      @(negedge clk);
      check("flush_req_held", 128'(dtcm_req_o), 128'(1));
      step();
      lsu_flush_i = 1'b0;
      @(negedge clk);
      check("flush_req_dropped", 128'({dtcm_req_o, lsu_busy_o}), 128'(0));

      // Flush while waiting for rvalid.
      step();
      issue(1'b1, 2'd2, 1'b0, 32'hB00, 32'h1, 5'd19);
      step();
      scramble();
      dtcm_gnt_i = 1'b1;
      step();
      dtcm_gnt_i = 1'b0;
      lsu_flush_i = 1'b1;
      @(negedge clk);
      check("flush_rsp_busy0", 128'(lsu_busy_o), 128'(1));
      step();
      lsu_flush_i = 1'b0;
      dtcm_rvalid_i = 1'b1;
      @(negedge clk);
      check("flush_rsp_busy1", 128'(lsu_busy_o), 128'(1));
      step();
      dtcm_rvalid_i = 1'b0;
      @(negedge clk);
      check("flush_rsp_done", 128'({lsu_ready_o, lsu_busy_o}), 128'(2'b10));

      // Flush coincident with grant behaves like a flush in RSP.
      step();
      issue(1'b0, 2'd0, 1'b0, 32'hC00, 32'h0, 5'd20);
      step();
      scramble();
      dtcm_gnt_i = 1'b1;
      lsu_flush_i = 1'b1;
      step();
      dtcm_gnt_i = 1'b0;
      lsu_flush_i = 1'b0;
      dtcm_rvalid_i = 1'b1;
      @(negedge clk);
      check("flush_gnt_busy", 128'(lsu_busy_o), 128'(1));
      step();
      dtcm_rvalid_i = 1'b0;
      @(negedge clk);
      check("flush_gnt_done", 128'(lsu_busy_o), 128'(0));

      // Flush in IDLE blocks the request.
      step();
      issue(1'b0, 2'd2, 1'b0, 32'hD00, 32'h0, 5'd21);
      lsu_flush_i = 1'b1;
      step();
      scramble();
      lsu_flush_i = 1'b0;
      @(negedge clk);
      check("flush_idle_blocked", 128'({dtcm_req_o, lsu_busy_o}), 128'(0));

      // Reset in RSP abandons the access; a late rvalid must not respond.
      step();
      issue(1'b0, 2'd2, 1'b0, 32'hE00, 32'h0, 5'd22);
      step();
      scramble();
      dtcm_gnt_i = 1'b1;
      step();
      dtcm_gnt_i = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check_quiet("reset_mid_access");
      step();
      rst = 1'b1;
      dtcm_rvalid_i = 1'b1;
      @(negedge clk);
      check("reset_late_rvalid_busy", 128'(lsu_busy_o), 128'(0));
      step();
      dtcm_rvalid_i = 1'b0;
      @(negedge clk);
      step();

      check("scoreboard_drained", 128'(sb.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv32i_lsu.md
RV32I_LSU -- requirements
Module: rv32i_lsu

Interface
REQ-001 Parameter WORD_WTH, 32, data width; SHALL be 32 or 64.
REQ-002 Parameter ADDR_WTH, 32, byte-address width.
REQ-003 Parameter REG_INX_WTH, 5, destination register index width.
REQ-004 Parameter TMO_WTH, 8, width of the bus-timeout counter.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-low.
REQ-007 lsu_valid_i  in  1  access request from pipeline.
REQ-008 lsu_ready_o  out  1  LSU can accept a request this cycle.
REQ-009 lsu_we_i  in  1  1 = store, 0 = load.
REQ-010 lsu_size_i  in  2  0 byte, 1 half, 2 word, 3 double (legal only if WORD_WTH=64).
REQ-011 lsu_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
REQ-012 lsu_addr_i / lsu_wdata_i / lsu_rd_inx_i  in  ADDR_WTH / WORD_WTH / REG_INX_WTH  byte address, store data, load destination.
REQ-013 lsu_flush_i  in  1  kill the in-flight access.
REQ-014 lsu_rsp_valid_o  out  1  one-cycle completion pulse.
REQ-015 lsu_rdata_o / lsu_rd_inx_o  out  WORD_WTH / REG_INX_WTH  extended load data, destination index.
REQ-016 lsu_misalign_o / lsu_err_o  out  1 / 1  misaligned-access flag, bus-timeout flag; valid with lsu_rsp_valid_o.
REQ-017 lsu_busy_o  out  1  LSU is not IDLE; drives the hazard-unit stall.
REQ-018 dtcm_req_o / dtcm_gnt_i  out / in  1 / 1  bus request and grant.
REQ-019 dtcm_we_o / dtcm_be_o / dtcm_addr_o / dtcm_wdata_o  out  1 / WORD_WTH/8 / ADDR_WTH / WORD_WTH  bus command fields.
REQ-020 dtcm_rvalid_i / dtcm_rdata_i  in  1 / WORD_WTH  response strobe and read data; rvalid completes both loads and stores.

Function
REQ-021 States are IDLE, REQ, RSP and MIS; lsu_ready_o SHALL be 1 only in IDLE.
REQ-022 Accept = lsu_valid_i and lsu_ready_o; the accepted command, offset, size, unsigned flag and rd index SHALL be registered.
REQ-023 Accept with an aligned address SHALL go to REQ; accept with a misaligned address (address mod access size is non-zero) or an illegal size SHALL go to MIS.
REQ-024 MIS SHALL last one cycle: it pulses lsu_rsp_valid_o with lsu_misalign_o=1, issues no bus request, then returns to IDLE.
REQ-025 In REQ, dtcm_req_o=1 with stable command fields until dtcm_gnt_i; grant moves the FSM to RSP.
REQ-026 dtcm_addr_o SHALL be the access address with its low log2(WORD_WTH/8) bits cleared.
REQ-027 dtcm_be_o SHALL be the size mask (1/3/F/FF) shifted left by the byte offset.
REQ-028 dtcm_wdata_o SHALL hold the store data lane replicated across the word.
REQ-029 On dtcm_rvalid_i in RSP, the next cycle SHALL pulse lsu_rsp_valid_o and return to IDLE.
REQ-030 Load data SHALL be dtcm_rdata_i shifted right by offset*8, then sign- or zero-extended from the access size; lsu_rdata_o SHALL be 0 for stores.
REQ-031 Minimum latency: accept at T, req at T+1, gnt at T+1, rvalid at T+2, lsu_rsp_valid_o at T+3.
REQ-032 A counter SHALL clear on accept and increment each cycle in REQ or RSP.
REQ-033 When the counter reaches 2^TMO_WTH-1: drop dtcm_req_o, pulse lsu_rsp_valid_o with lsu_err_o=1 next cycle, return to IDLE, and ignore any later rvalid.
REQ-034 lsu_flush_i in REQ before grant SHALL deassert dtcm_req_o next cycle and return to IDLE with no response.
REQ-035 lsu_flush_i in RSP SHALL wait for rvalid (or timeout), then return to IDLE with no response pulse.
REQ-036 lsu_flush_i in REQ coincident with dtcm_gnt_i SHALL follow the RSP rule.
REQ-037 lsu_flush_i in IDLE SHALL block acceptance in that cycle.

Reset
REQ-038 Reset SHALL force state IDLE and counter 0.
REQ-039 Under reset: lsu_ready_o=1, lsu_busy_o=0, and every other output 0.
REQ-040 Reset mid-access SHALL abandon the access with no response.

Structure
REQ-041 Package rv32i_lsu_pkg SHALL hold the state enum, the size encodings and the byte-enable mask constants.
REQ-042 Combinational sub-module rv32i_lsu_align SHALL hold lane steering, byte-enable generation and load extension.

Verification
REQ-043 Load byte signed: addr 0x103, rdata 0x80FF_FF12, gnt+rvalid immediate -> be=1000, addr 0x100, rsp at T+3, rdata 0xFFFF_FF80.
REQ-044 Store half: addr 0x202, wdata 0x0000_ABCD, gnt delayed 3 cycles -> req held 4 cycles, be=1100, wdata 0xABCD_ABCD, single rsp, err=0.
REQ-045 Misaligned word load at 0x301 -> no dtcm_req_o, rsp next cycle with misalign=1, ready restored.
REQ-046 TMO_WTH=3, gnt never asserted -> req dropped after 7 cycles, rsp with err=1, FSM in IDLE.
REQ-047 Flush during REQ, then flush during RSP -> no rsp pulse in either case; busy clears on the cycle after the rvalid.
REQ-048 Reset asserted during RSP -> all outputs zero, ready=1; a late rvalid produces no response.
